// File: rtl/id_stage_if.sv
// Fetch/execute-facing signal bundle for the decode stage.
// The master side is fetch+execute (the environment); the slave side is id_stage.
interface id_stage_if #(
    parameter int unsigned CNT_W = 16
);
    logic              if_valid_i;
    logic              if_ready_o;
    logic [31:0]       if_pc_i;
    logic [31:0]       if_instr_i;
    logic              flush_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [31:0]       id_pc_o;
    logic [5:0]        id_opcode_o;
    logic [4:0]        id_rs_o;
    logic [4:0]        id_rt_o;
    logic [4:0]        id_wrs_o;
    logic [4:0]        id_shamt_o;
    logic [5:0]        id_funct_o;
    logic [31:0]       id_imm_o;
    logic [25:0]       id_jtarget_o;
    logic [1:0]        id_fmt_o;
    logic              id_rf_we_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output if_valid_i, if_pc_i, if_instr_i, flush_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_opcode_o, id_rs_o, id_rt_o,
               id_wrs_o, id_shamt_o, id_funct_o, id_imm_o, id_jtarget_o,
               id_fmt_o, id_rf_we_o, stall_cnt_o
    );

    modport slave (
        input  if_valid_i, if_pc_i, if_instr_i, flush_i, id_ready_i,
        output if_ready_o, id_valid_o, id_pc_o, id_opcode_o, id_rs_o, id_rt_o,
               id_wrs_o, id_shamt_o, id_funct_o, id_imm_o, id_jtarget_o,
               id_fmt_o, id_rf_we_o, stall_cnt_o
    );
endinterface

// File: rtl/id_stage.sv
// Decode stage: small {pc, instr} FIFO behind fetch, combinational field
// decode of the head entry, saturating back-pressure counter.
module id_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    id_stage_if.slave  bus
);
    localparam int unsigned    PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pc;
    logic [31:0]      w_instr;
    logic [5:0]       w_op;
    logic [1:0]       w_fmt;
    logic [4:0]       w_wrs;
    logic             w_we;
    logic [31:0]      w_imm;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.if_valid_i && !w_full;
    assign w_pop   = !w_empty && bus.id_ready_i;

    // Entry storage; contents are don't-care until counted, so no reset
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush_i) begin
            r_pc_mem[r_wr_ptr]    <= bus.if_pc_i;
            r_instr_mem[r_wr_ptr] <= bus.if_instr_i;
        end
    end

    // Pointers and occupancy; flush overrides any push/pop this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of cycles execute held back a valid head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_empty && !bus.id_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Head-entry decode; every field reads as zero while the buffer is empty
    always_comb begin
        w_pc    = '0;
        w_instr = '0;
        w_op    = '0;
        w_fmt   = 2'b00;
        w_wrs   = '0;
        w_we    = 1'b0;
        w_imm   = '0;
        if (!w_empty) begin
            w_pc    = r_pc_mem[r_rd_ptr];
            w_instr = r_instr_mem[r_rd_ptr];
            w_op    = w_instr[31:26];
            if (w_op == 6'd0) begin
                w_fmt = 2'b00;
                w_wrs = w_instr[15:11];
            end else if (w_op == 6'd2 || w_op == 6'd3) begin
                w_fmt = 2'b10;
                w_wrs = (w_op == 6'd3) ? 5'd31 : 5'd0;
            end else begin
                w_fmt = 2'b01;
                w_wrs = w_instr[20:16];
            end
            w_we = !(w_op[5:3] == 3'b101) && !(w_op[5:2] == 4'b0001) &&
                   (w_op != 6'd1) && (w_op != 6'd2) && (w_wrs != 5'd0);
            if (w_op == 6'h0C || w_op == 6'h0D || w_op == 6'h0E)
                w_imm = {16'h0000, w_instr[15:0]};
            else
                w_imm = {{16{w_instr[15]}}, w_instr[15:0]};
        end
    end

    assign bus.if_ready_o   = !w_full;
    assign bus.id_valid_o   = !w_empty;
    assign bus.id_pc_o      = w_pc;
    assign bus.id_opcode_o  = w_op;
    assign bus.id_rs_o      = w_instr[25:21];
    assign bus.id_rt_o      = w_instr[20:16];
    assign bus.id_wrs_o     = w_wrs;
    assign bus.id_shamt_o   = w_instr[10:6];
    assign bus.id_funct_o   = w_instr[5:0];
    assign bus.id_imm_o     = w_imm;
    assign bus.id_jtarget_o = w_instr[25:0];
    assign bus.id_fmt_o     = w_fmt;
    assign bus.id_rf_we_o   = w_we;
    assign bus.stall_cnt_o  = r_stall_cnt;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_id_stage;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned SMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_if #(.CNT_W(CNT_W)) bus ();
    id_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          errors = 0;
    int          checks = 0;
    logic [63:0] q[$];
    int unsigned m_stall = 0;
    bit          acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode rules as an instruction-class table
    task automatic expect_fields(input logic [31:0] ins, output logic [1:0] fmt,
                                 output logic [4:0] wrs, output logic we, output logic [31:0] imm);
        int op;
        op = int'(ins[31:26]);
        if (op == 0) begin
            fmt = 2'd0; wrs = ins[15:11];
        end else if (op == 2 || op == 3) begin
            fmt = 2'd2; wrs = (op == 3) ? 5'd31 : 5'd0;
        end else begin
            fmt = 2'd1; wrs = ins[20:16];
        end
        we = 1'b1;
        if (op >= 40 && op <= 47) we = 1'b0;                 // stores
        if (op == 1 || op == 2 || (op >= 4 && op <= 7)) we = 1'b0;
        if (wrs == 5'd0) we = 1'b0;
        if (op >= 12 && op <= 14) imm = {16'h0000, ins[15:0]};
        else                      imm = 32'($signed(ins[15:0]));
    endtask

    task automatic compare_model();
        logic [31:0] pc, ins, imm;
        logic [1:0]  fmt;
        logic [4:0]  wrs;
        logic        we, v;
        v = (q.size() != 0);
        if (v) begin
            pc  = q[0][63:32];
            ins = q[0][31:0];
            expect_fields(ins, fmt, wrs, we, imm);
        end else begin
            pc = '0; ins = '0; fmt = '0; wrs = '0; we = 1'b0; imm = '0;
        end
        chk("id_valid", 32'(bus.id_valid_o), 32'(v));
        chk("if_ready", 32'(bus.if_ready_o), 32'(q.size() != DEPTH));
        chk("id_pc", bus.id_pc_o, pc);
        chk("opcode", 32'(bus.id_opcode_o), 32'(ins[31:26]));
        chk("rs", 32'(bus.id_rs_o), 32'(ins[25:21]));
        chk("rt", 32'(bus.id_rt_o), 32'(ins[20:16]));
        chk("wrs", 32'(bus.id_wrs_o), 32'(wrs));
        chk("shamt", 32'(bus.id_shamt_o), 32'(ins[10:6]));
        chk("funct", 32'(bus.id_funct_o), 32'(ins[5:0]));
        chk("imm", bus.id_imm_o, imm);
        chk("jtarget", 32'(bus.id_jtarget_o), 32'(ins[25:0]));
        chk("fmt", 32'(bus.id_fmt_o), 32'(fmt));
        chk("rf_we", 32'(bus.id_rf_we_o), 32'(we));
        chk("stall_cnt", 32'(bus.stall_cnt_o), m_stall);
    endtask

    // One clock: drive, predict handshakes, step the model, compare
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl, output bit accepted);
        bit push, pop, stall;
        bus.if_valid_i = v;
        bus.if_pc_i    = pc;
        bus.if_instr_i = ins;
        bus.id_ready_i = rdy;
        bus.flush_i    = fl;
        push  = v && (q.size() != DEPTH);
        pop   = (q.size() != 0) && rdy;
        stall = (q.size() != 0) && !rdy;
        @(posedge clk);
        #1;
        if (stall && m_stall != SMAX) m_stall++;
        if (fl) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({pc, ins});
        end
        accepted = push && !fl;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.if_valid_i = 1'b0; bus.if_pc_i = '0; bus.if_instr_i = '0;
        bus.id_ready_i = 1'b0; bus.flush_i = 1'b0;
        #2;
        q.delete();
        m_stall = 0;
        compare_model();
        chk("rst_valid_lit", 32'(bus.id_valid_o), 32'd0);
        chk("rst_ready_lit", 32'(bus.if_ready_o), 32'd1);
        chk("rst_stall_lit", 32'(bus.stall_cnt_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [10] = '{6'd0, 6'd2, 6'd3, 6'd12, 6'd13, 6'd14, 6'd15, 6'd43, 6'd4, 6'd35};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r[31:26] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 7) == 0) begin r[15:11] = 5'd0; r[20:16] = 5'd0; end
        return r;
    endfunction

    initial begin
        logic        hold_v;
        logic [31:0] hold_pc, hold_ins;

        do_reset();

        // add r3,r1,r2
        cycle(1'b1, 32'h0, 32'h0022_1820, 1'b1, 1'b0, acc);
        chk("add_valid", 32'(bus.id_valid_o), 32'd1);
        chk("add_fmt", 32'(bus.id_fmt_o), 32'd0);
        chk("add_rs", 32'(bus.id_rs_o), 32'd1);
        chk("add_rt", 32'(bus.id_rt_o), 32'd2);
        chk("add_wrs", 32'(bus.id_wrs_o), 32'd3);
        chk("add_funct", 32'(bus.id_funct_o), 32'h20);
        chk("add_we", 32'(bus.id_rf_we_o), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk("add_gone", 32'(bus.id_valid_o), 32'd0);

        // immediates and write-enable classes
        cycle(1'b1, 32'h4, 32'h2001_FFFF, 1'b1, 1'b0, acc);
        chk("addi_imm", bus.id_imm_o, 32'hFFFF_FFFF);
        chk("addi_fmt", 32'(bus.id_fmt_o), 32'd1);
        chk("addi_wrs", 32'(bus.id_wrs_o), 32'd1);
        chk("addi_we", 32'(bus.id_rf_we_o), 32'd1);
        cycle(1'b1, 32'h8, 32'h3401_FFFF, 1'b1, 1'b0, acc);
        chk("ori_imm", bus.id_imm_o, 32'h0000_FFFF);
        cycle(1'b1, 32'hC, 32'hAC22_0004, 1'b1, 1'b0, acc);
        chk("sw_we", 32'(bus.id_rf_we_o), 32'd0);
        cycle(1'b1, 32'h10, 32'h1022_0003, 1'b1, 1'b0, acc);
        chk("beq_we", 32'(bus.id_rf_we_o), 32'd0);
        cycle(1'b1, 32'h14, 32'h0C00_0010, 1'b1, 1'b0, acc);
        chk("jal_fmt", 32'(bus.id_fmt_o), 32'd2);
        chk("jal_wrs", 32'(bus.id_wrs_o), 32'd31);
        chk("jal_we", 32'(bus.id_rf_we_o), 32'd1);
        chk("jal_jt", 32'(bus.id_jtarget_o), 32'h10);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // back-pressure: fill, hold third, drain in order
        do_reset();
        cycle(1'b1, 32'h0, 32'h0022_1820, 1'b0, 1'b0, acc);
        chk("bp_stall0", 32'(bus.stall_cnt_o), 32'd0);
        cycle(1'b1, 32'h4, 32'h2001_FFFF, 1'b0, 1'b0, acc);
        chk("bp_full", 32'(bus.if_ready_o), 32'd0);
        chk("bp_stall1", 32'(bus.stall_cnt_o), 32'd1);
        cycle(1'b1, 32'h8, 32'h3401_FFFF, 1'b0, 1'b0, acc);
        chk("bp_stall2", 32'(bus.stall_cnt_o), 32'd2);
        chk("bp_head0", bus.id_pc_o, 32'h0);
        cycle(1'b1, 32'h8, 32'h3401_FFFF, 1'b1, 1'b0, acc);
        chk("bp_head4", bus.id_pc_o, 32'h4);
        cycle(1'b1, 32'h8, 32'h3401_FFFF, 1'b1, 1'b0, acc);
        chk("bp_head8", bus.id_pc_o, 32'h8);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk("bp_empty", 32'(bus.id_valid_o), 32'd0);

        // streaming push+pop, pointers wrap, occupancy stays one
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(4 * i), rand_instr(), 1'b1, 1'b0, acc);
            chk("stream_pc", bus.id_pc_o, 32'(4 * i));
            chk("stream_ready", 32'(bus.if_ready_o), 32'd1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // flush on a full buffer with pop and push attempted
        cycle(1'b1, 32'h40, rand_instr(), 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h44, rand_instr(), 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h48, rand_instr(), 1'b1, 1'b1, acc);
        chk("flush_valid", 32'(bus.id_valid_o), 32'd0);
        chk("flush_ready", 32'(bus.if_ready_o), 32'd1);
        cycle(1'b1, 32'h100, 32'h2001_FFFF, 1'b0, 1'b0, acc);
        chk("post_flush_pc", bus.id_pc_o, 32'h100);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk("post_flush_sole", 32'(bus.id_valid_o), 32'd0);

        // randomized traffic with fetch holding stalled instructions
        hold_v = 1'b0; hold_pc = '0; hold_ins = '0;
        for (int n = 0; n < 600; n++) begin
            logic        v, rdy, fl;
            logic [31:0] pc, ins;
            if (n == 300) begin
                do_reset();
                hold_v = 1'b0;
            end
            if (hold_v) begin
                v = 1'b1; pc = hold_pc; ins = hold_ins;
            end else begin
                v   = ($urandom_range(0, 3) != 0);
                pc  = $urandom & 32'hFFFF_FFFC;
                ins = rand_instr();
            end
            rdy = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 29) == 0);
            cycle(v, pc, ins, rdy, fl, acc);
            hold_v   = v && !acc && !fl;
            hold_pc  = pc;
            hold_ins = ins;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
